lcd_line_scheduler: RTL
=======================

Name: lcd_line_scheduler

Overview:
- Sequences the 16x2 character LCD and shares its byte writer between two line sources.
  - Line 0: plaintext hex characters.
  - Line 1: DES output hex characters.
- Runs the HD44780 init sequence once, then services per-line refresh requests round-robin.
- Snapshots each line's 16 x 9-bit character vector before writing it, so the panel never shows a torn line.
- Sits between the Bit_Converter arrays and the LCD byte writer (start/done handshake).

Parameters:
- DLY_CYCLES, 262142, idle cycles after each byte's done before the next byte.
- DLY_W, 18, width of the delay counter; must satisfy DLY_CYCLES < 2**DLY_W.
- TIMEOUT_CYCLES, 1023, watchdog limit on wr_done; used only with the optional feature.

Ports:
- iCLK  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- req  in  2  refresh request pulses; bit0 = line 0, bit1 = line 1
- line0_chars  in  144  line 0 characters; char k = [143-9k -: 9], bit 8 = RS, [7:0] = byte
- line1_chars  in  144  line 1 characters, same packing
- wr_data  out  8  byte to the writer
- wr_rs  out  1  0 = command, 1 = data
- wr_start  out  1  start request to the writer
- wr_done  in  1  writer completion
- grant  out  2  one-hot line being written; 0 during init and idle
- busy  out  1  high whenever not in IDLE
- init_done  out  1  sticky high once init completes
- frame_done  out  1  one-cycle pulse when a line finishes
- err  out  1  sticky watchdog error

Behaviour:
- Reset values: wr_data=0, wr_rs=0, wr_start=0, grant=0, busy=1, init_done=0, frame_done=0, err=0, pending=0, rr_ptr=0, state=INIT.
- States:
  - INIT: issue bytes 0x38, 0x0C, 0x01, 0x06 (RS=0) through SEND; after the 4th, init_done<=1 and go to IDLE.
  - IDLE: when pending!=0, pick a line, set grant, copy that line's chars into the 144-bit shadow, clear its pending bit, go to ADDR.
  - ADDR: send 0x80 (line 0) or 0xC0 (line 1), RS=0, via SEND.
  - CHAR: send shadow chars k=0..15 (wr_rs = bit 8, wr_data = [7:0]) via SEND.
  - After k=15: frame_done=1 for one cycle, rr_ptr <= served line ^ 1, grant=0, return to IDLE in the same cycle.
- SEND sub-sequence (one byte):
  - Cycle 1: drive wr_data/wr_rs; they stay stable until the byte's delay expires.
  - Cycle 2: wr_start=1, held until wr_done is sampled 1; wr_start drops the next cycle.
  - Delay: counter runs 0..DLY_CYCLES-1, then advance to the next byte.
  - Byte period = 2 + handshake + DLY_CYCLES cycles.
- Pending and arbitration:
  - req[i]=1 sets pending[i] in any state, including INIT.
  - If a set and an IDLE-grant clear of the same bit coincide, the set wins.
  - Only pending[0] set -> line 0. Only pending[1] set -> line 1. Both set -> line rr_ptr.
  - First contest after reset goes to line 0.
  - A request for the line currently being written stays pending; that line is rewritten afterwards with fresh data.
- Shadow: loaded only at grant. Input changes mid-line have no effect until the next grant.
- rst=1 mid-line or mid-init: all state returns to reset values next cycle; init reruns; pending requests are discarded.
- busy = (state != IDLE). The grant cycle out of IDLE already shows busy=1.

Optional Feature:
- Macro: LCD_SCHED_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles while wr_start=1 and wr_done=0.
  - On reaching TIMEOUT_CYCLES: drop wr_start, set err=1 (sticky until rst), skip the delay, treat the byte as done.
  - The sequence continues, so the display recovers after a stuck writer.
- Undefined: no watchdog; SEND waits indefinitely on wr_done; err tied 0.

Test Plan (bench uses DLY_CYCLES=4, writer model returns wr_done 3 cycles after wr_start rises):
- Reset then run: wr_start handshakes carry 0x38, 0x0C, 0x01, 0x06 with RS=0 -> init_done=1, busy=0, grant=0.
- req=2'b01 with line0_chars all 9'h130 -> 17 bytes: 0x80 RS=0, then sixteen 0x30 RS=1; grant=2'b01 throughout; one frame_done pulse; back to IDLE.
- req=2'b11 in one cycle after reset/init -> line 0 served first (0x80...), then line 1 (0xC0...); two frame_done pulses; grant 01 then 10.
- Change line0_chars to all 9'h141 during the 5th char of line 0 -> remaining chars still 0x30; an extra req=01 mid-line -> line rewritten afterwards with 0x41.
- Assert rst for 1 cycle during line 1 char 8 -> all outputs return to reset values; next bytes are 0x38...; pending line discarded.
- With LCD_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, writer never asserts wr_done -> wr_start drops after 16 cycles, err=1, next init byte 0x0C issued; without the macro, wr_start stays high and err=0.

Source files
------------

// File: rtl/lcd_line_scheduler.sv
// lcd_line_scheduler: shares one HD44780 byte writer between two 16-char line
// sources. It runs the panel init sequence once, then writes whole lines on
// request with round-robin arbitration. Each line is snapshotted into a shadow
// register at grant time, so the panel never shows a half-updated line.
// Optional feature macro: LCD_SCHED_TIMEOUT_EN (watchdog on wr_done, sets err).
module lcd_line_scheduler #(
    parameter int DLY_CYCLES     = 262142,
    parameter int DLY_W          = 18,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         iCLK,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [143:0] line0_chars,
    input  logic [143:0] line1_chars,
    output logic [7:0]   wr_data,
    output logic         wr_rs,
    output logic         wr_start,
    input  logic         wr_done,
    output logic [1:0]   grant,
    output logic         busy,
    output logic         init_done,
    output logic         frame_done,
    output logic         err
);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ADDR, ST_CHAR} stateT;
    typedef enum logic [1:0] {PH_DRIVE, PH_START, PH_WAIT, PH_DELAY} phaseT;

    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DLY_CYCLES - 1);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

    stateT            state;
    phaseT            phase;
    logic [DLY_W-1:0] dlyCnt;
    logic [1:0]       initIdx;
    logic [3:0]       charIdx;
    logic [1:0]       pending;
    logic             rrPtr;
    logic             servedLine;
    logic [143:0]     shadow;

    logic             pickLine;
    logic [1:0]       pendClr;
    logic [7:0]       curByte;
    logic             curRs;
    logic [143:0]     charWin;
    logic             byteEnd;

`ifdef LCD_SCHED_TIMEOUT_EN
    localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    logic [TO_W-1:0]           wdCnt;
    logic                      wdHit;
`else
    logic [31:0]               unusedTimeout;
    assign unusedTimeout = 32'(TIMEOUT_CYCLES);
`endif

    // HD44780 init command list: 8-bit 2-line, display on, clear, entry mode.
    function automatic logic [7:0] initByte(input logic [1:0] idx);
        case (idx)
            2'd0:    initByte = 8'h38;
            2'd1:    initByte = 8'h0C;
            2'd2:    initByte = 8'h01;
            default: initByte = 8'h06;
        endcase
    endfunction

    // Arbitration choice, byte selection and end-of-byte detection.
    always_comb begin
        pickLine = 1'b0;
        pendClr  = 2'b00;
        curByte  = 8'h00;
        curRs    = 1'b0;
        charWin  = shadow << (8'd9 * {4'd0, charIdx});
        byteEnd  = 1'b0;
`ifdef LCD_SCHED_TIMEOUT_EN
        wdHit    = 1'b0;
`endif

        // Single requester wins outright; a contest goes to rrPtr.
        if (pending == 2'b10) begin
            pickLine = 1'b1;
        end else if (pending == 2'b01) begin
            pickLine = 1'b0;
        end else begin
            pickLine = rrPtr;
        end

        if ((state == ST_IDLE) && (pending != 2'b00)) begin
            pendClr = pickLine ? 2'b10 : 2'b01;
        end else begin
            pendClr = 2'b00;
        end

        case (state)
            ST_INIT: begin
                curByte = initByte(initIdx);
                curRs   = 1'b0;
            end
            ST_ADDR: begin
                curByte = servedLine ? 8'hC0 : 8'h80;
                curRs   = 1'b0;
            end
            ST_CHAR: begin
                curRs   = charWin[143];
                curByte = charWin[142:135];
            end
            default: begin
                curByte = 8'h00;
                curRs   = 1'b0;
            end
        endcase

        if ((phase == PH_DELAY) && (dlyCnt == DLY_LAST)) begin
            byteEnd = 1'b1;
        end else begin
            byteEnd = 1'b0;
        end

`ifdef LCD_SCHED_TIMEOUT_EN
        // A stuck writer is abandoned and the byte counts as finished.
        if ((phase == PH_WAIT) && !wr_done && (wdCnt == TO_LAST)) begin
            wdHit   = 1'b1;
            byteEnd = 1'b1;
        end else begin
            wdHit   = 1'b0;
        end
`endif
    end

    // Main sequencer: init, arbitration, per-byte send/handshake/delay.
    always_ff @(posedge iCLK) begin
        if (rst) begin
            state      <= ST_INIT;
            phase      <= PH_DRIVE;
            dlyCnt     <= '0;
            initIdx    <= 2'd0;
            charIdx    <= 4'd0;
            pending    <= 2'b00;
            rrPtr      <= 1'b0;
            servedLine <= 1'b0;
            shadow     <= '0;
            wr_data    <= 8'h00;
            wr_rs      <= 1'b0;
            wr_start   <= 1'b0;
            grant      <= 2'b00;
            busy       <= 1'b1;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
`ifdef LCD_SCHED_TIMEOUT_EN
            wdCnt      <= '0;
`endif
        end else begin
            // A new request beats a simultaneous grant clear of the same bit.
            pending    <= (pending & ~pendClr) | req;
            frame_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pending != 2'b00) begin
                        grant      <= pickLine ? 2'b10 : 2'b01;
                        servedLine <= pickLine;
                        shadow     <= pickLine ? line1_chars : line0_chars;
                        state      <= ST_ADDR;
                        phase      <= PH_DRIVE;
                        busy       <= 1'b1;
                    end else begin
                        busy       <= 1'b0;
                    end
                end
                ST_INIT, ST_ADDR, ST_CHAR: begin
                    case (phase)
                        PH_DRIVE: begin
                            wr_data <= curByte;
                            wr_rs   <= curRs;
                            phase   <= PH_START;
                        end
                        PH_START: begin
                            wr_start <= 1'b1;
                            phase    <= PH_WAIT;
`ifdef LCD_SCHED_TIMEOUT_EN
                            wdCnt    <= '0;
`endif
                        end
                        PH_WAIT: begin
                            if (wr_done) begin
                                wr_start <= 1'b0;
                                dlyCnt   <= '0;
                                phase    <= PH_DELAY;
`ifdef LCD_SCHED_TIMEOUT_EN
                            end else if (wdHit) begin
                                wr_start <= 1'b0;
                                err      <= 1'b1;
                            end else begin
                                wdCnt    <= wdCnt + TO_ONE;
`endif
                            end
                        end
                        PH_DELAY: begin
                            if (!byteEnd) begin
                                dlyCnt <= dlyCnt + DLY_ONE;
                            end
                        end
                        default: begin
                            phase <= PH_DRIVE;
                        end
                    endcase

                    // Byte finished: move on to the next byte or the next state.
                    if (byteEnd) begin
                        case (state)
                            ST_INIT: begin
                                if (initIdx == 2'd3) begin
                                    init_done <= 1'b1;
                                    state     <= ST_IDLE;
                                    busy      <= 1'b0;
                                end else begin
                                    initIdx   <= initIdx + 2'd1;
                                end
                                phase <= PH_DRIVE;
                            end
                            ST_ADDR: begin
                                state   <= ST_CHAR;
                                charIdx <= 4'd0;
                                phase   <= PH_DRIVE;
                            end
                            ST_CHAR: begin
                                if (charIdx == 4'd15) begin
                                    frame_done <= 1'b1;
                                    rrPtr      <= ~servedLine;
                                    grant      <= 2'b00;
                                    state      <= ST_IDLE;
                                    busy       <= 1'b0;
                                end else begin
                                    charIdx    <= charIdx + 4'd1;
                                end
                                phase <= PH_DRIVE;
                            end
                            default: begin
                                state <= ST_INIT;
                            end
                        endcase
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule
